// File: rtl/ibex_wb_pkg.sv
// Shared types for the register-file writeback stage: RF address type,
// the registered write entry, and the architectural register count.
package ibex_wb_pkg;

    localparam int unsigned RegAddrW   = 5;
    // Widest supported write data; the top zero-extends into this and only drives out DataWidth bits.
    localparam int unsigned WbDataWMax = 64;
    localparam int unsigned NumRegsI   = 32;
    localparam int unsigned NumRegsE   = 16;

    typedef logic [RegAddrW-1:0] reg_addr_t;

    typedef struct packed {
        logic                  we;
        reg_addr_t             waddr;
        logic [WbDataWMax-1:0] wdata;
    } wb_entry_t;

    function automatic int unsigned num_regs(input bit rv32e);
        return rv32e ? NumRegsE : NumRegsI;
    endfunction

endpackage

// File: rtl/ibex_rf_writeback_if.sv
// EX result and LSU load handshakes into the writeback stage.
interface ibex_rf_writeback_if
    import ibex_wb_pkg::*;
#(
    parameter int unsigned DataWidth = 32
);
    logic                 ex_valid;
    logic                 ex_we;
    reg_addr_t            ex_waddr;
    logic [DataWidth-1:0] ex_wdata;
    logic                 ex_ready;

    logic                 lsu_req;
    reg_addr_t            lsu_req_waddr;
    logic                 lsu_req_ready;
    logic                 lsu_rvalid;
    logic [DataWidth-1:0] lsu_rdata;
    logic                 lsu_err;

    modport master (
        output ex_valid, ex_we, ex_waddr, ex_wdata,
        output lsu_req, lsu_req_waddr, lsu_rvalid, lsu_rdata, lsu_err,
        input  ex_ready, lsu_req_ready
    );

    modport slave (
        input  ex_valid, ex_we, ex_waddr, ex_wdata,
        input  lsu_req, lsu_req_waddr, lsu_rvalid, lsu_rdata, lsu_err,
        output ex_ready, lsu_req_ready
    );

endinterface

// File: rtl/ibex_wb_dest_fifo.sv
// In-order FIFO of outstanding load destinations. Head is always slot 0; a pop
// shifts the array down so valid entries stay packed at the low slots.
module ibex_wb_dest_fifo
    import ibex_wb_pkg::*;
#(
    parameter  int unsigned Depth = 2,
    localparam int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      push_i,
    input  reg_addr_t                 push_addr_i,
    input  logic                      pop_i,
    output reg_addr_t                 head_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [CntW-1:0]           count_o,
    output logic [Depth*RegAddrW-1:0] entries_o,
    output logic [Depth-1:0]          entry_valid_o
);

    reg_addr_t [Depth-1:0] mem_q, mem_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [CntW-1:0]       wr_idx;
    logic                  do_push, do_pop;

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    // With a simultaneous pop the new entry lands one slot lower.
    assign wr_idx  = cnt_q - CntW'(do_pop);

    always_comb begin
        mem_d = mem_q;
        if (do_pop) begin
            for (int i = 0; i < int'(Depth) - 1; i++) mem_d[i] = mem_q[i+1];
        end
        if (do_push) begin
            for (int i = 0; i < int'(Depth); i++) begin
                if (CntW'(i) == wr_idx) mem_d[i] = push_addr_i;
            end
        end
        cnt_d = cnt_q + CntW'(do_push) - CntW'(do_pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        entry_valid_o = '0;
        for (int i = 0; i < int'(Depth); i++) entry_valid_o[i] = (CntW'(i) < cnt_q);
    end

    assign head_o    = mem_q[0];
    assign count_o   = cnt_q;
    assign entries_o = mem_q;

endmodule

// File: rtl/ibex_rf_writeback.sv
// Writeback stage: arbitrates EX results against load responses into one registered
// RF write and tracks pending load destinations for RAW/WAW hazard detection.
module ibex_rf_writeback
    import ibex_wb_pkg::*;
#(
    parameter  bit          RV32E          = 1'b0,
    parameter  int unsigned DataWidth      = 32,
    parameter  int unsigned MaxOutstanding = 2,
    localparam int unsigned CntW           = $clog2(MaxOutstanding + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    ibex_rf_writeback_if.slave   bus,
    input  reg_addr_t            raddr_a_i,
    input  reg_addr_t            raddr_b_i,
    output logic                 hazard_a_o,
    output logic                 hazard_b_o,
    output logic                 rf_we_o,
    output reg_addr_t            rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o,
    output logic                 load_err_o,
    output logic [CntW-1:0]      outstanding_o
);

    localparam int unsigned NumRegs = num_regs(RV32E);
    localparam int unsigned IdxW    = RV32E ? 4 : 5;

    reg_addr_t                          fifo_head;
    logic                               fifo_full, fifo_empty;
    logic [MaxOutstanding*RegAddrW-1:0] fifo_entries;
    logic [MaxOutstanding-1:0]          fifo_valid;
    logic                               load_push, load_ret, ex_accept;
    logic [NumRegs-1:0]                 pending;
    reg_addr_t                          ent;
    wb_entry_t                          wb_d, wb_q;
    logic                               load_err_q;

    assign bus.lsu_req_ready = ~fifo_full;
    assign load_push         = bus.lsu_req & ~fifo_full;
    assign load_ret          = bus.lsu_rvalid & ~fifo_empty;

    ibex_wb_dest_fifo #(
        .Depth (MaxOutstanding)
    ) u_dest_fifo (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .push_i        (load_push),
        .push_addr_i   (bus.lsu_req_waddr),
        .pop_i         (bus.lsu_rvalid),
        .head_o        (fifo_head),
        .full_o        (fifo_full),
        .empty_o       (fifo_empty),
        .count_o       (outstanding_o),
        .entries_o     (fifo_entries),
        .entry_valid_o (fifo_valid)
    );

    // Scoreboard is rebuilt from the live FIFO entries, so a duplicate destination
    // stays pending until its last load has returned.
    always_comb begin
        pending = '0;
        ent     = '0;
        for (int i = 0; i < int'(MaxOutstanding); i++) begin
            ent = fifo_entries[i*RegAddrW +: RegAddrW];
            if (fifo_valid[i]) pending[ent[IdxW-1:0]] = 1'b1;
        end
        pending[0] = 1'b0;
    end

    assign hazard_a_o = pending[raddr_a_i[IdxW-1:0]];
    assign hazard_b_o = pending[raddr_b_i[IdxW-1:0]];

    // Load responses cannot be stalled, so they own the write port outright.
    assign bus.ex_ready = ~bus.lsu_rvalid & ~(bus.ex_we & pending[bus.ex_waddr[IdxW-1:0]]);
    assign ex_accept    = bus.ex_valid & bus.ex_ready;

    always_comb begin
        wb_d    = wb_q;
        wb_d.we = 1'b0;
        if (load_ret && !bus.lsu_err) begin
            wb_d.we    = (fifo_head != '0);
            wb_d.waddr = fifo_head;
            wb_d.wdata = WbDataWMax'(bus.lsu_rdata);
        end else if (ex_accept && bus.ex_we) begin
            wb_d.we    = (bus.ex_waddr != '0);
            wb_d.waddr = bus.ex_waddr;
            wb_d.wdata = WbDataWMax'(bus.ex_wdata);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wb_q       <= '0;
            load_err_q <= 1'b0;
        end else begin
            wb_q       <= wb_d;
            load_err_q <= bus.lsu_rvalid & (fifo_empty | bus.lsu_err);
        end
    end

    assign rf_we_o    = wb_q.we;
    assign rf_waddr_o = wb_q.waddr;
    assign rf_wdata_o = wb_q.wdata[DataWidth-1:0];
    assign load_err_o = load_err_q;

    if (DataWidth < WbDataWMax) begin : g_wdata_hi
        logic unused_wdata_hi;
        assign unused_wdata_hi = ^wb_q.wdata[WbDataWMax-1:DataWidth];
    end

endmodule
